// File: rtl/key_cmd_pkg.sv
// Shared key codes, FSM state encoding and helpers for the keypad command decoder.
package key_cmd_pkg;

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] KEY_NONE     = 4'd0;
    localparam logic [CODE_W-1:0] KEY_FREQ_UP  = 4'd1;
    localparam logic [CODE_W-1:0] KEY_FREQ_DN  = 4'd2;
    localparam logic [CODE_W-1:0] KEY_DEPTH_UP = 4'd3;
    localparam logic [CODE_W-1:0] KEY_DEPTH_DN = 4'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    function automatic logic is_cmd_code(input logic [CODE_W-1:0] code);
        return (code >= KEY_FREQ_UP) && (code <= KEY_DEPTH_DN);
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Loadable down-counter used to time hold-before-repeat and repeat intervals.
module key_hold_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Holds at zero rather than wrapping; the FSM reloads before it would matter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/key_cmd_decoder.sv
// Turns synchronised keypad codes into command pulses and saturating freq/depth indices.
// Hold-to-auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_cmd_decoder
    import key_cmd_pkg::*;
#(
    parameter int unsigned FREQ_MAX      = 15,
    parameter int unsigned FREQ_DEFAULT  = 4,
    parameter int unsigned DEPTH_MAX     = 7,
    parameter int unsigned DEPTH_DEFAULT = 4,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [CODE_W-1:0] key_code,
    input  logic              key_pressed,
    output logic [3:0]        freq_sel,
    output logic [2:0]        depth_sel,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic              at_limit
);

    logic [CODE_W-1:0] code_m, code_s;
    logic              pressed_m, pressed_s;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            code_m    <= KEY_NONE;
            code_s    <= KEY_NONE;
            pressed_m <= 1'b0;
            pressed_s <= 1'b0;
        end else begin
            code_m    <= key_code;
            code_s    <= code_m;
            pressed_m <= key_pressed;
            pressed_s <= pressed_m;
        end
    end

    state_e            state;
    logic [CODE_W-1:0] held_code;
    logic              active;
    logic              still_held;

    assign active     = pressed_s && is_cmd_code(code_s);
    assign still_held = active && (code_s == held_code);

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_load_value;
    logic [CNT_W-1:0] unused_tmr_value;
    logic             tmr_zero;

    key_hold_timer #(
        .WIDTH (CNT_W)
    ) u_hold_timer (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .value      (unused_tmr_value),
        .zero       (tmr_zero)
    );
`else
    logic unused_timing_cfg;
    assign unused_timing_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    logic              fire;
    logic [CODE_W-1:0] fire_code;

    always_comb begin
        fire      = 1'b0;
        fire_code = held_code;
`ifdef KEY_AUTOREPEAT_EN
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_load_value = CNT_W'(REPEAT_CYCLES - 1);
`endif
        case (state)
            IDLE: begin
                if (active) begin
                    fire      = 1'b1;
                    fire_code = code_s;
`ifdef KEY_AUTOREPEAT_EN
                    tmr_load       = 1'b1;
                    tmr_load_value = CNT_W'(HOLD_CYCLES - 1);
`endif
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            HOLD, REPEAT: begin
                if (still_held) begin
                    if (tmr_zero) begin
                        fire     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    logic [3:0] freq_d;
    logic [2:0] depth_d;
    logic       limit;

    // Saturate at either end; a blocked step still reports as a command, flagged by limit.
    always_comb begin
        freq_d  = freq_sel;
        depth_d = depth_sel;
        limit   = 1'b0;
        if (fire) begin
            case (fire_code)
                KEY_FREQ_UP: begin
                    if (freq_sel == 4'(FREQ_MAX)) limit = 1'b1;
                    else freq_d = freq_sel + 4'd1;
                end
                KEY_FREQ_DN: begin
                    if (freq_sel == 4'd0) limit = 1'b1;
                    else freq_d = freq_sel - 4'd1;
                end
                KEY_DEPTH_UP: begin
                    if (depth_sel == 3'(DEPTH_MAX)) limit = 1'b1;
                    else depth_d = depth_sel + 3'd1;
                end
                KEY_DEPTH_DN: begin
                    if (depth_sel == 3'd0) limit = 1'b1;
                    else depth_d = depth_sel - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            held_code <= KEY_NONE;
            cmd_valid <= 1'b0;
            cmd_code  <= KEY_NONE;
            at_limit  <= 1'b0;
            freq_sel  <= 4'(FREQ_DEFAULT);
            depth_sel <= 3'(DEPTH_DEFAULT);
        end else begin
            cmd_valid <= fire;
            at_limit  <= limit;
            freq_sel  <= freq_d;
            depth_sel <= depth_d;
            if (fire) cmd_code <= fire_code;

            case (state)
                IDLE: begin
                    if (active) begin
                        held_code <= code_s;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!still_held) begin
                        state <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
                    end else if (tmr_zero) begin
                        state <= REPEAT;
`endif
                    end
                end
`ifdef KEY_AUTOREPEAT_EN
                REPEAT: begin
                    if (!still_held) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder with a scoreboard of expected command pulses.
// Adapts its expectations to whether KEY_AUTOREPEAT_EN is defined.
module tb_key_cmd_decoder;
    import key_cmd_pkg::*;

    localparam int unsigned HOLD = 100;
    localparam int unsigned REP  = 20;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic       key_pressed = 1'b0;
    logic [3:0] freq_sel;
    logic [2:0] depth_sel;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       at_limit;

    key_cmd_decoder #(
        .FREQ_MAX      (15),
        .FREQ_DEFAULT  (4),
        .DEPTH_MAX     (7),
        .DEPTH_DEFAULT (4),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .freq_sel    (freq_sel),
        .depth_sel   (depth_sel),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .at_limit    (at_limit)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic [3:0] freq;
        logic [2:0] depth;
        logic       limit;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_freq = 4;
    int   m_depth = 4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Model one executed command and queue the pulse it should produce.
    task automatic expect_cmd(input logic [3:0] code, input int at_cyc);
        exp_t e;
        logic lim;
        lim = 1'b0;
        case (code)
            4'd1: if (m_freq == 15) lim = 1'b1; else m_freq++;
            4'd2: if (m_freq == 0) lim = 1'b1; else m_freq--;
            4'd3: if (m_depth == 7) lim = 1'b1; else m_depth++;
            4'd4: if (m_depth == 0) lim = 1'b1; else m_depth--;
            default: ;
        endcase
        e.cyc   = at_cyc;
        e.code  = code;
        e.freq  = m_freq[3:0];
        e.depth = m_depth[2:0];
        e.limit = lim;
        sb_q.push_back(e);
    endtask

    always @(negedge clk_in) begin
        if (!rst) begin
            if ((sb_q.size() > 0) && (cyc > sb_q[0].cyc)) begin
                mon_e = sb_q.pop_front();
                check("missed_pulse", cyc, mon_e.cyc);
            end
            if (cmd_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {31'd0, cmd_valid}, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("cmd_code", {28'd0, cmd_code}, {28'd0, mon_e.code});
                    check("at_limit", {31'd0, at_limit}, {31'd0, mon_e.limit});
                    check("freq_sel", {28'd0, freq_sel}, {28'd0, mon_e.freq});
                    check("depth_sel", {29'd0, depth_sel}, {29'd0, mon_e.depth});
                end
            end else if (at_limit) begin
                check("stray_limit", {31'd0, cmd_valid}, 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic p);
        key_code    = c;
        key_pressed = p;
    endtask

    task automatic check_indices(input string tag);
        check({tag, "_freq"}, {28'd0, freq_sel}, 32'(m_freq));
        check({tag, "_depth"}, {29'd0, depth_sel}, 32'(m_depth));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_freq"}, {28'd0, freq_sel}, 4);
        check({tag, "_depth"}, {29'd0, depth_sel}, 4);
        check({tag, "_valid"}, {31'd0, cmd_valid}, 0);
        check({tag, "_code"}, {28'd0, cmd_code}, 0);
        check({tag, "_limit"}, {31'd0, at_limit}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int s;
        int target;

        // Reset values
        tick(2);
        check_reset_state("reset");
        rst = 1'b0;
        tick(3);

        // Short press of freq up: one pulse, 3 edges after the input change
        d = cyc;
        drive(4'd1, 1'b1);
        expect_cmd(4'd1, d + 3);
        tick(10);
        drive(4'd0, 1'b0);
        tick(8);
        check_indices("short_press");

        // Long hold of depth up
        d = cyc;
        drive(4'd3, 1'b1);
        expect_cmd(4'd3, d + 3);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) expect_cmd(4'd3, d + 3 + HOLD + k * REP);
`endif
        tick(200);
        drive(4'd0, 1'b0);
        tick(8);
        check_indices("long_hold");

        // Code change while held acts as release then a new press
        d = cyc;
        drive(4'd2, 1'b1);
        expect_cmd(4'd2, d + 3);
        tick(10);
        s = cyc;
        drive(4'd4, 1'b1);
        expect_cmd(4'd4, s + 4);
        tick(10);
        drive(4'd0, 1'b0);
        tick(8);
        check_indices("code_change");

        // Pressed with non-command codes is ignored
        drive(4'd0, 1'b1);
        tick(10);
        drive(4'd9, 1'b1);
        tick(10);
        drive(4'd15, 1'b1);
        tick(10);
        drive(4'd0, 1'b0);
        tick(5);
        check_indices("invalid_codes");

        // Walk freq up, then hold so freq_sel reaches 10 before a mid-hold reset
`ifdef KEY_AUTOREPEAT_EN
        target = 8;
`else
        target = 9;
`endif
        while (m_freq < target) begin
            d = cyc;
            drive(4'd1, 1'b1);
            expect_cmd(4'd1, d + 3);
            tick(6);
            drive(4'd0, 1'b0);
            tick(6);
        end
        d = cyc;
        drive(4'd1, 1'b1);
        expect_cmd(4'd1, d + 3);
`ifdef KEY_AUTOREPEAT_EN
        expect_cmd(4'd1, d + 3 + HOLD);
`endif
        tick(109);
        check("pre_reset_freq", {28'd0, freq_sel}, 10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        m_freq  = 4;
        m_depth = 4;
        tick(3);
        rst = 1'b0;
        d = cyc;
        expect_cmd(4'd1, d + 3);
        tick(10);
        drive(4'd0, 1'b0);
        tick(8);
        check_indices("after_reset");

        // Depth down to zero and beyond: later presses blocked
        for (int k = 0; k < 6; k++) begin
            d = cyc;
            drive(4'd4, 1'b1);
            expect_cmd(4'd4, d + 3);
            tick(6);
            drive(4'd0, 1'b0);
            tick(6);
        end
        check_indices("depth_floor");

        // Freq up to FREQ_MAX and beyond
        for (int k = 0; k < 12; k++) begin
            d = cyc;
            drive(4'd1, 1'b1);
            expect_cmd(4'd1, d + 3);
            tick(6);
            drive(4'd0, 1'b0);
            tick(6);
        end
        check_indices("freq_ceiling");

        // Freq down once from the ceiling
        d = cyc;
        drive(4'd2, 1'b1);
        expect_cmd(4'd2, d + 3);
        tick(6);
        drive(4'd0, 1'b0);
        tick(10);
        check_indices("final");
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_cmd_decoder.md
Name: key_cmd_decoder

Overview:
Consumer side of the keypad interface. It takes the encoded key code (0 = none, 1..4 = key) and the pressed flag from the key scanner. It turns them into single-cycle command pulses, with optional hold-to-auto-repeat. It maintains the AM carrier-frequency index and modulation-depth index that feed the modulator/NCO configuration.

Parameters:
FREQ_MAX, 15, highest carrier-frequency index; freq_sel saturates at this value.
FREQ_DEFAULT, 4, freq_sel value after reset.
DEPTH_MAX, 7, highest modulation-depth index.
DEPTH_DEFAULT, 4, depth_sel value after reset.
HOLD_CYCLES, 50_000_000, clk_in cycles a key must be held before the first repeat (1 s at 50 MHz).
REPEAT_CYCLES, 10_000_000, clk_in cycles between repeats while held (5 Hz).

Ports:
clk_in  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
key_code  in  4  encoded key from the scanner: 0 none, 1 freq up, 2 freq down, 3 depth up, 4 depth down.
key_pressed  in  1  scanner pressed flag; level signal, changes on the slow scan tick.
freq_sel  out  4  carrier-frequency index, 0..FREQ_MAX.
depth_sel  out  3  modulation-depth index, 0..DEPTH_MAX.
cmd_valid  out  1  one-cycle pulse per executed command.
cmd_code  out  4  code of the command executed; valid when cmd_valid is high, holds its last value otherwise.
at_limit  out  1  one-cycle pulse, coincident with cmd_valid, when the command was blocked by saturation.

Behaviour:
- Reset (async assert, sync release):
  - freq_sel = FREQ_DEFAULT; depth_sel = DEPTH_DEFAULT.
  - cmd_valid = 0; cmd_code = 0; at_limit = 0.
  - FSM = IDLE; hold counter = 0; synchroniser flops = 0.
- Input capture: key_code and key_pressed pass through a 2-flop synchroniser. The FSM sees only the synchronised pair (code_s, pressed_s).
- "Active" means pressed_s = 1 and code_s is in 1..4. Codes 0 or 5..15 with pressed_s = 1 are treated as not active and ignored.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: when active, execute the command (see below) on the same edge, load counter = HOLD_CYCLES-1, latch code_s into held_code, go to HOLD. Otherwise stay in IDLE.
  - HOLD: if not active or code_s != held_code, go to IDLE with no command. Else if counter = 0, execute held_code, load counter = REPEAT_CYCLES-1, go to REPEAT. Else decrement the counter.
  - REPEAT: same release/change rule as HOLD. At counter = 0, execute held_code and reload REPEAT_CYCLES-1.
- A code change while held is treated as a release. The new code then fires from IDLE one cycle later, with no press lost.
- Latency: after an input change, cmd_valid rises on the 3rd rising clk_in edge (2 synchroniser stages + 1 FSM register). freq_sel/depth_sel update on that same edge.
- Executing a command:
  - Pulse cmd_valid for one cycle and set cmd_code = the code.
  - Code 1: freq_sel += 1. Code 2: freq_sel -= 1. Code 3: depth_sel += 1. Code 4: depth_sel -= 1.
  - Saturating arithmetic; no wrap. Up at MAX or down at 0 leaves the value unchanged and pulses at_limit with cmd_valid.
- Counter width is clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). Counter wrap is never used.
- Reset mid-hold: state, counter and indices return to reset values immediately. A key still held after reset release counts as a new press and fires once, about 3 cycles later.

Optional Feature:
KEY_AUTOREPEAT_EN: when defined, the REPEAT state and the HOLD-to-REPEAT transition exist as described. When undefined, HOLD only waits for release or code change. Exactly one command per press, REPEAT is absent, the counter is removed, and HOLD_CYCLES/REPEAT_CYCLES are unused.

Decomposition:
- Package key_cmd_pkg:
  - Key code constants KEY_NONE=0, KEY_FREQ_UP=1, KEY_FREQ_DN=2, KEY_DEPTH_UP=3, KEY_DEPTH_DN=4.
  - FSM state encoding IDLE/HOLD/REPEAT.
- Sub-module key_hold_timer: loadable down-counter with load, value and zero-flag outputs. Instantiated only under KEY_AUTOREPEAT_EN.

Test Plan:
- Press code 1 for 10 cycles with HOLD_CYCLES=100 (sim override), then release -> exactly one cmd_valid (cycle 3, cmd_code=1); freq_sel 4->5; at_limit stays 0.
- Hold code 3 for 200 cycles, HOLD=100, REPEAT=20, KEY_AUTOREPEAT_EN defined -> pulses at cycles 3, 103, 123, 143, 163, 183; depth_sel saturates at 7 after 3 steps; remaining pulses carry at_limit=1.
- Same stimulus with KEY_AUTOREPEAT_EN undefined -> single pulse; depth_sel 4->5.
- Hold code 2, switch to code 4 without release -> second pulse 1 cycle after HOLD exit with cmd_code=4; freq_sel 3, depth_sel 3.
- Key_pressed=1 with code 0, then code 9 -> no cmd_valid; indices unchanged.
- Assert rst while in REPEAT with freq_sel=10 -> freq_sel=4 and cmd_valid=0 asynchronously. With the key still held after release -> one new pulse at cycle 3.
